// File: rtl/bitserial_logic_processor_if.sv
// Host-side bus for bitserial_logic_processor.
// master: host that drives loads, Execute, function/routing select and step count.
// slave : the processor; returns register contents plus Busy/Done status.
//   LoadA/LoadB  level load strobes for A/B (Din)
//   Execute      level start request
//   F, R         function and routing select, used on every shift
//   Steps        shifts per operation (0 or >WIDTH means WIDTH)
//   Aval/Bval    register contents
//   Busy/Done    shifting in progress / one-cycle completion pulse
interface bitserial_logic_processor_if #(
  parameter int WIDTH = 16
);
  localparam int SW = $clog2(WIDTH + 1);

  logic             LoadA;
  logic             LoadB;
  logic             Execute;
  logic [WIDTH-1:0] Din;
  logic [2:0]       F;
  logic [1:0]       R;
  logic [SW-1:0]    Steps;
  logic [WIDTH-1:0] Aval;
  logic [WIDTH-1:0] Bval;
  logic             Busy;
  logic             Done;

  modport master (
    output LoadA, LoadB, Execute, Din, F, R, Steps,
    input  Aval, Bval, Busy, Done
  );

  modport slave (
    input  LoadA, LoadB, Execute, Din, F, R, Steps,
    output Aval, Bval, Busy, Done
  );
endinterface

// File: rtl/bitserial_logic_processor.sv
// Bit-serial logic processor: two WIDTH-bit shift registers A and B shift
// right together; a selectable bitwise function of the outgoing LSBs and a
// routing select decide what enters the MSBs.
// Ports:
//   Clk    system clock, rising edge
//   Reset  asynchronous, active-high; clears registers, counter and FSM
//   bus    slave modport of bitserial_logic_processor_if (loads, Execute,
//          F/R/Steps in; Aval/Bval/Busy/Done out)
//
// state | meaning
// IDLE  | waiting for Execute; loads accepted
// SHIFT | one shift per clock until the latched step count runs out
// HOLD  | operation finished, Execute still high; loads accepted, no retrigger
module bitserial_logic_processor #(
  parameter int WIDTH = 16
) (
  input  logic                         Clk,
  input  logic                         Reset,
  bitserial_logic_processor_if.slave   bus
);
  localparam int SW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] a_q, b_q;
  logic [SW-1:0]    count;
  logic [SW-1:0]    eff_steps;
  logic             done_q;
  logic             f_bit;
  logic             new_a, new_b;
  logic             last_shift;

  // Zero or an out-of-range count runs a full-width operation.
  always_comb begin
    eff_steps = bus.Steps;
    if (bus.Steps == '0 || bus.Steps > SW'(WIDTH))
      eff_steps = SW'(WIDTH);
  end

  always_comb begin
    f_bit = 1'b0;
    case (bus.F)
      3'b000: f_bit = a_q[0] & b_q[0];
      3'b001: f_bit = a_q[0] | b_q[0];
      3'b010: f_bit = a_q[0] ^ b_q[0];
      3'b011: f_bit = 1'b1;
      3'b100: f_bit = ~(a_q[0] & b_q[0]);
      3'b101: f_bit = ~(a_q[0] | b_q[0]);
      3'b110: f_bit = ~(a_q[0] ^ b_q[0]);
      default: f_bit = 1'b0;
    endcase
  end

  always_comb begin
    new_a = a_q[0];
    new_b = b_q[0];
    case (bus.R)
      2'b00: begin new_a = a_q[0]; new_b = b_q[0]; end
      2'b01: begin new_a = a_q[0]; new_b = f_bit;  end
      2'b10: begin new_a = f_bit;  new_b = b_q[0]; end
      default: begin new_a = b_q[0]; new_b = a_q[0]; end
    endcase
  end

  assign last_shift = (state == SHIFT) && (count == SW'(1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (bus.Execute) next_state = SHIFT;
      SHIFT: if (count == SW'(1)) next_state = bus.Execute ? HOLD : IDLE;
      HOLD:  if (!bus.Execute) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      a_q    <= '0;
      b_q    <= '0;
      count  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= last_shift;
      if (state == SHIFT) begin
        a_q   <= {new_a, a_q[WIDTH-1:1]};
        b_q   <= {new_b, b_q[WIDTH-1:1]};
        count <= count - SW'(1);
      end else begin
        // A load coinciding with Execute in IDLE lands before the first shift.
        if (bus.LoadA) a_q <= bus.Din;
        if (bus.LoadB) b_q <= bus.Din;
        if (state == IDLE && bus.Execute) count <= eff_steps;
      end
    end
  end

  assign bus.Aval = a_q;
  assign bus.Bval = b_q;
  assign bus.Busy = (state == SHIFT);
  assign bus.Done = done_q;
endmodule

// File: tb/tb_bitserial_logic_processor.sv
module tb_bitserial_logic_processor;
  localparam int WIDTH = 16;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int   tests = 0;
  int   failed = 0;

  always #5 Clk = ~Clk;

  bitserial_logic_processor_if #(.WIDTH(WIDTH)) bus ();

  bitserial_logic_processor #(.WIDTH(WIDTH)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [2:0]  f;
    logic [1:0]  r;
    logic [4:0]  steps;
    logic [15:0] a_exp;
    logic [15:0] b_exp;
    int          n;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_ab(input logic [15:0] a, input logic [15:0] b);
    @(negedge Clk);
    bus.Din = a; bus.LoadA = 1'b1;
    @(negedge Clk);
    bus.LoadA = 1'b0; bus.Din = b; bus.LoadB = 1'b1;
    @(negedge Clk);
    bus.LoadB = 1'b0;
  endtask

  // Called at a falling edge; holds Execute for 'hold' samples, then releases.
  task automatic run_op(input int hold, output int busy_n, output int done_n,
                        output int done_at, output logic [15:0] a_at,
                        output logic [15:0] b_at);
    busy_n = 0; done_n = 0; done_at = 0; a_at = 'x; b_at = 'x;
    bus.Execute = 1'b1;
    for (int i = 1; i <= hold + 3; i++) begin
      @(posedge Clk); #1;
      if (bus.Busy) busy_n++;
      if (bus.Done) begin
        done_n++; done_at = i; a_at = bus.Aval; b_at = bus.Bval;
      end
      if (i == hold) begin
        @(negedge Clk);
        bus.Execute = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n, done_n, done_at, guard;
    logic [15:0] a_at, b_at;

    vecs[0]  = '{16'h3333, 16'h5555, 3'd2, 2'd2, 5'd0,  16'h6666, 16'h5555, 16};
    vecs[1]  = '{16'h6666, 16'h5555, 3'd6, 2'd1, 5'd0,  16'h6666, 16'hCCCC, 16};
    vecs[2]  = '{16'h6666, 16'hCCCC, 3'd0, 2'd3, 5'd0,  16'hCCCC, 16'h6666, 16};
    vecs[3]  = '{16'h1234, 16'hABCD, 3'd0, 2'd0, 5'd4,  16'h4123, 16'hDABC, 4};
    vecs[4]  = '{16'h1234, 16'hABCD, 3'd0, 2'd0, 5'd20, 16'h1234, 16'hABCD, 16};
    vecs[5]  = '{16'h0000, 16'h0000, 3'd3, 2'd2, 5'd0,  16'hFFFF, 16'h0000, 16};
    vecs[6]  = '{16'hFFFF, 16'h5A5A, 3'd7, 2'd1, 5'd0,  16'hFFFF, 16'h0000, 16};
    vecs[7]  = '{16'h00CC, 16'h00AA, 3'd0, 2'd2, 5'd8,  16'h8800, 16'hAA00, 8};
    vecs[8]  = '{16'h00CC, 16'h00AA, 3'd1, 2'd2, 5'd8,  16'hEE00, 16'hAA00, 8};
    vecs[9]  = '{16'h00CC, 16'h00AA, 3'd4, 2'd2, 5'd8,  16'h7700, 16'hAA00, 8};
    vecs[10] = '{16'h00CC, 16'h00AA, 3'd5, 2'd2, 5'd8,  16'h1100, 16'hAA00, 8};
    vecs[11] = '{16'h00CC, 16'h00AA, 3'd6, 2'd2, 5'd8,  16'h9900, 16'hAA00, 8};
    vecs[12] = '{16'h00CC, 16'h00AA, 3'd2, 2'd2, 5'd8,  16'h6600, 16'hAA00, 8};
    vecs[13] = '{16'h0001, 16'h0000, 3'd1, 2'd2, 5'd1,  16'h8000, 16'h0000, 1};
    vecs[14] = '{16'h1234, 16'hABCD, 3'd0, 2'd0, 5'd15, 16'h2468, 16'h579B, 15};
    vecs[15] = '{16'h1234, 16'hABCD, 3'd0, 2'd0, 5'd16, 16'h1234, 16'hABCD, 16};
    vecs[16] = '{16'h1234, 16'hABCD, 3'd0, 2'd0, 5'd17, 16'h1234, 16'hABCD, 16};

    bus.LoadA = 0; bus.LoadB = 0; bus.Execute = 0;
    bus.Din = '0; bus.F = '0; bus.R = '0; bus.Steps = '0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk); #1;
    check("reset_a", 32'(bus.Aval), 32'h0);
    check("reset_b", 32'(bus.Bval), 32'h0);
    check("reset_busy", 32'(bus.Busy), 32'h0);
    check("reset_done", 32'(bus.Done), 32'h0);

    foreach (vecs[k]) begin
      load_ab(vecs[k].a_in, vecs[k].b_in);
      bus.F = vecs[k].f; bus.R = vecs[k].r; bus.Steps = vecs[k].steps;
      run_op(24, busy_n, done_n, done_at, a_at, b_at);
      check($sformatf("v%0d_a", k), 32'(a_at), 32'(vecs[k].a_exp));
      check($sformatf("v%0d_b", k), 32'(b_at), 32'(vecs[k].b_exp));
      check($sformatf("v%0d_busy_cycles", k), 32'(busy_n), 32'(vecs[k].n));
      check($sformatf("v%0d_done_pulses", k), 32'(done_n), 32'h1);
      check($sformatf("v%0d_done_latency", k), 32'(done_at), 32'(vecs[k].n + 1));
      check($sformatf("v%0d_a_after_hold", k), 32'(bus.Aval), 32'(vecs[k].a_exp));
    end

    // Load while shifting is ignored; the same load in HOLD is taken.
    load_ab(16'h1234, 16'h0000);
    bus.F = 3'd0; bus.R = 2'd0; bus.Steps = 5'd0;
    bus.Execute = 1'b1;
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    bus.Din = 16'hFFFF; bus.LoadA = 1'b1;
    @(negedge Clk);
    bus.LoadA = 1'b0;
    guard = 0;
    while (!bus.Done && guard < 40) begin
      @(posedge Clk); #1; guard++;
    end
    check("busy_load_done_seen", 32'(bus.Done), 32'h1);
    check("busy_load_ignored", 32'(bus.Aval), 32'h1234);
    @(negedge Clk);
    bus.Din = 16'hFFFF; bus.LoadA = 1'b1;
    @(posedge Clk); #1;
    check("hold_load_taken", 32'(bus.Aval), 32'hFFFF);
    check("hold_not_busy", 32'(bus.Busy), 32'h0);
    @(negedge Clk);
    bus.LoadA = 1'b0; bus.Execute = 1'b0;
    @(posedge Clk); #1;
    check("hold_exit_busy", 32'(bus.Busy), 32'h0);

    // Asynchronous reset between edges in the middle of an operation.
    load_ab(16'hABCD, 16'h1234);
    bus.Execute = 1'b1;
    repeat (5) @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    check("async_rst_a", 32'(bus.Aval), 32'h0);
    check("async_rst_b", 32'(bus.Bval), 32'h0);
    check("async_rst_busy", 32'(bus.Busy), 32'h0);
    check("async_rst_done", 32'(bus.Done), 32'h0);
    @(negedge Clk);
    bus.Execute = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    load_ab(16'h1234, 16'hABCD);
    bus.Steps = 5'd0; bus.R = 2'd0;
    run_op(20, busy_n, done_n, done_at, a_at, b_at);
    check("post_rst_busy_cycles", 32'(busy_n), 32'd16);
    check("post_rst_done_pulses", 32'(done_n), 32'd1);
    check("post_rst_a", 32'(a_at), 32'h1234);

    // Load and Execute on the same IDLE edge: shift uses the loaded value.
    load_ab(16'h1234, 16'h0000);
    @(negedge Clk);
    bus.Din = 16'h0001; bus.LoadA = 1'b1; bus.Execute = 1'b1;
    bus.F = 3'd1; bus.R = 2'd2; bus.Steps = 5'd1;
    @(negedge Clk);
    bus.LoadA = 1'b0; bus.Execute = 1'b0;
    @(posedge Clk); #1;
    check("same_edge_done", 32'(bus.Done), 32'h1);
    check("same_edge_a", 32'(bus.Aval), 32'h8000);
    check("same_edge_b", 32'(bus.Bval), 32'h0000);
    @(posedge Clk); #1;
    check("same_edge_done_clears", 32'(bus.Done), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
